// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and presents the captured opcode/operand to the decoder with valid/ready.
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [3:0]           opcode,
  output logic [INSTR_W-5:0]   operand,
  output logic [ADDR_W-1:0]    pc_out,
  input  logic                 jump,
  input  logic [ADDR_W-1:0]    jump_target,
  output logic [15:0]          instr_count,
  output logic [1:0]           dbg_state
);

  // Handshakes: a memory read completes in any FETCH cycle with imem_ack=1
  // (req/addr held until then); an instruction transfers in any HOLD cycle with
  // instr_valid=1 and instr_ready=1, and jump/jump_target count only then.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    pc_out_q;
  logic [INSTR_W-1:0]   ir_q;
  logic [15:0]          count_q;
  logic                 capture;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      pc_out_q <= '0;
      ir_q     <= '0;
      count_q  <= '0;
    end else begin
      if (capture) begin
        ir_q     <= imem_rdata;
        pc_out_q <= pc_q;
      end
      if (accept) begin
        // The PC increment wraps naturally at 2^ADDR_W.
        pc_q <= jump ? jump_target : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign opcode      = ir_q[INSTR_W-1 -: 4];
  assign operand     = ir_q[INSTR_W-5:0];
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small instruction memory model with
// automatic (zero-wait) or manual ack, and one task per scenario.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [7:0]  pc_out;
  logic        jump;
  logic [7:0]  jump_target;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  logic [15:0] mem [0:255];
  logic        auto_ack;
  logic        man_ack;
  logic        ovr_en;
  logic [15:0] ovr_data;

  int total;
  int bad;

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = ovr_en ? ovr_data : mem[imem_addr];

  instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .pc_out      (pc_out),
    .jump        (jump),
    .jump_target (jump_target),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset;
    rst_n       = 1'b0;
    run         = 1'b0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_target = 8'h00;
    auto_ack    = 1'b1;
    man_ack     = 1'b0;
    ovr_en      = 1'b0;
    ovr_data    = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    total++; if ({opcode, operand} !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", {opcode, operand}); end
    total++; if (pc_out !== 8'h00) begin bad++; $display("FAIL reset_pc_out got=%h exp=00", pc_out); end
    total++; if (instr_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", instr_count); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_stream;
    logic       exp_req   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_valid [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_addr  [5] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02};
    run = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (imem_req !== exp_req[i]) begin bad++; $display("FAIL stream_req[%0d] got=%b exp=%b", i, imem_req, exp_req[i]); end
      total++; if (instr_valid !== exp_valid[i]) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, instr_valid, exp_valid[i]); end
      total++; if (imem_addr !== exp_addr[i]) begin bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr, exp_addr[i]); end
      if (i == 1) begin
        total++; if (opcode !== 4'h0 || operand !== 12'h123 || pc_out !== 8'h00) begin
          bad++; $display("FAIL stream_first got=%h/%h/%h exp=0/123/00", opcode, operand, pc_out); end
      end
      if (i == 3) begin
        total++; if (opcode !== 4'h1 || operand !== 12'h456 || pc_out !== 8'h01) begin
          bad++; $display("FAIL stream_second got=%h/%h/%h exp=1/456/01", opcode, operand, pc_out); end
      end
    end
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL stream_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_ack_delay;
    apply_reset();
    auto_ack = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) man_ack = 1'b1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL delay_wait[%0d] got=req%b addr%h valid%b exp=req1 addr00 valid0", i, imem_req, imem_addr, instr_valid); end
    end
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || opcode !== 4'h0 || operand !== 12'h123) begin
      bad++; $display("FAIL delay_capture got=valid%b %h/%h exp=valid1 0/123", instr_valid, opcode, operand); end
    ovr_en = 1'b1;
    ovr_data = 16'hF999;
    man_ack = 1'b1;
    @(negedge clk);
    total++; if (opcode !== 4'h0 || operand !== 12'h123 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL delay_spurious got=%h/%h valid%b req%b exp=0/123 valid1 req0", opcode, operand, instr_valid, imem_req); end
    man_ack = 1'b0;
    ovr_en = 1'b0;
  endtask

  task automatic test_back_pressure;
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || opcode !== 4'h0 || operand !== 12'h123 || pc_out !== 8'h00) begin
        bad++; $display("FAIL bp_hold[%0d] got=valid%b req%b %h/%h pc%h exp=valid1 req0 0/123 pc00", i, instr_valid, imem_req, opcode, operand, pc_out); end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=req%b addr%h valid%b exp=req1 addr01 valid0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_jump;
    logic found;
    apply_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_out === 8'h05) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL jump_reach_pc5 got=%b exp=1", found); end
    jump = 1'b1;
    jump_target = 8'h40;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      bad++; $display("FAIL jump_taken got=req%b addr%h exp=req1 addr40", imem_req, imem_addr); end
    jump = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || opcode !== 4'hA || operand !== 12'h040) begin
      bad++; $display("FAIL jump_fetch got=valid%b pc%h %h/%h exp=valid1 pc40 A/040", instr_valid, pc_out, opcode, operand); end
    instr_ready = 1'b0;
    jump = 1'b1;
    jump_target = 8'h80;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || imem_addr !== 8'h40 || imem_req !== 1'b0) begin
      bad++; $display("FAIL jump_no_accept got=valid%b pc%h addr%h req%b exp=valid1 pc40 addr40 req0", instr_valid, pc_out, imem_addr, imem_req); end
    jump = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h41) begin
      bad++; $display("FAIL jump_ignored got=req%b addr%h exp=req1 addr41", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    apply_reset();
    instr_ready = 1'b1;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    jump = 1'b1;
    jump_target = 8'hFF;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin
      bad++; $display("FAIL wrap_to_ff got=req%b addr%h exp=req1 addrff", imem_req, imem_addr); end
    jump = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'hFF || operand !== 12'h0FF) begin
      bad++; $display("FAIL wrap_hold got=valid%b pc%h op%h exp=valid1 pcff op0ff", instr_valid, pc_out, operand); end
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL wrap_addr got=req%b addr%h exp=req1 addr00", imem_req, imem_addr); end
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    @(negedge clk);
    @(negedge clk);
    total++; if (instr_count !== 16'hFFFF) begin bad++; $display("FAIL count_reach_max got=%h exp=ffff", instr_count); end
    @(negedge clk);
    @(negedge clk);
    total++; if (instr_count !== 16'hFFFF) begin bad++; $display("FAIL count_saturate got=%h exp=ffff", instr_count); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    auto_ack = 1'b0;
    run = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_fetch_pre got=%b exp=1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL rst_fetch_async got=req%b addr%h valid%b st%0d exp=req0 addr00 valid0 st0", imem_req, imem_addr, instr_valid, dbg_state); end
    run = 1'b0;
    auto_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL rst_fetch_idle got=req%b valid%b exp=req0 valid0", imem_req, instr_valid); end
    run = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h01 || instr_count !== 16'd1 || operand !== 12'h456) begin
      bad++; $display("FAIL rst_hold_pre got=valid%b pc%h cnt%0d op%h exp=valid1 pc01 cnt1 op456", instr_valid, pc_out, instr_count, operand); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00 || pc_out !== 8'h00 ||
                 opcode !== 4'h0 || operand !== 12'h000 || instr_count !== 16'h0000) begin
      bad++; $display("FAIL rst_hold_async got=valid%b req%b addr%h pc%h %h/%h cnt%h exp=all zero",
                      instr_valid, imem_req, imem_addr, pc_out, opcode, operand, instr_count); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL rst_hold_idle got=req%b valid%b st%0d exp=req0 valid0 st0", imem_req, instr_valid, dbg_state); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0] = 16'h0123;
    mem[1] = 16'h1456;
    mem[2] = 16'h2789;
    test_reset();
    test_stream();
    test_ack_delay();
    test_back_pressure();
    test_jump();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the opcode decoder (control unit). It holds the program counter and issues single-word reads to instruction memory over a req/ack handshake. It captures the returned word in an instruction register and presents its 4-bit opcode and 12-bit operand field to the decoder with a valid/ready handshake. It consumes the decoder's jump signal to redirect the PC, and counts accepted instructions.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-memory address width (2..12)
- INSTR_W, 16, instruction width; opcode = [INSTR_W-1:INSTR_W-4], operand = [INSTR_W-5:0]

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- run  input  1  fetch enable; sampled only in IDLE
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  read address (current PC)
- imem_ack  input  1  memory has returned imem_rdata this cycle
- imem_rdata  input  INSTR_W  instruction word, valid when imem_ack=1
- instr_valid  output  1  opcode/operand/pc_out hold a fetched instruction
- instr_ready  input  1  downstream accepts the instruction
- opcode  output  4  instruction register [INSTR_W-1:INSTR_W-4]
- operand  output  INSTR_W-4  instruction register low field
- pc_out  output  ADDR_W  address the presented instruction was fetched from
- jump  input  1  decoder jump request, qualified by accept
- jump_target  input  ADDR_W  redirect address, sampled with jump
- instr_count  output  16  number of accepted instructions, saturating

## Operation
- The block has three states: IDLE, FETCH, and HOLD.
- IDLE:
  - imem_req=0 and instr_valid=0.
  - If run=1, go to FETCH.
  - If run=0, stay in IDLE.
- FETCH:
  - imem_req=1, and imem_addr=PC, held stable until ack.
  - When imem_ack=1: load the instruction register from imem_rdata, set pc_out=PC, and go to HOLD.
- HOLD:
  - instr_valid=1, with opcode, operand and pc_out stable.
  - On accept (instr_valid and instr_ready):
    - if jump=1, PC←jump_target; otherwise PC←PC+1 mod 2^ADDR_W;
    - instr_count increments;
    - go to FETCH.
  - Without accept, stay in HOLD with all outputs unchanged.
- jump and jump_target are ignored unless accept occurs in the same cycle.
- imem_ack is ignored in IDLE and HOLD; no data is captured.
- PC wrap: PC=2^ADDR_W-1 with no jump gives next PC=0.
- instr_count saturates at 16'hFFFF and does not wrap.
- run is not re-checked after leaving IDLE. Fetching continues until reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, PC=0, instruction register=0, pc_out=0, instr_count=0;
  - imem_req=0, imem_addr=0, instr_valid=0, opcode=0, operand=0.
- Reset asserted mid-FETCH or mid-HOLD aborts immediately. There is no pending request or instruction after release.
- First cycle after rst_n rises: IDLE. If run=1 in that cycle, imem_req=1 with addr 0 in the next cycle.
- Ack latency is unbounded. imem_ack may be high in the first cycle of req (zero-wait memory).
- Ack in cycle N: instr_valid=1 from cycle N+1.
- Accept in cycle M: imem_req=1 with the new PC from cycle M+1, and instr_valid=0 in cycle M+1.
- Throughput with zero-wait memory and ready held high is one instruction per 2 cycles.
- All outputs are registered or decoded only from state.
- No combinational path exists from instr_ready, jump or imem_ack to any output.

## Test plan
- Reset, then run=1 with zero-wait memory returning 16'h0123, 16'h1456, ... and ready=1:
  - imem_addr sequence is 0,1,2,...;
  - opcode 0 then 1;
  - operand 12'h123 then 12'h456;
  - instr_valid pulses on alternate cycles;
  - instr_count=2 after the second accept.
- Memory ack delayed 3 cycles:
  - imem_req stays 1 and imem_addr stays stable for all 4 cycles;
  - instr_valid rises the cycle after ack;
  - spurious ack while in HOLD does not change opcode.
- Back-pressure: hold ready=0 for 5 cycles in HOLD:
  - outputs are frozen and no imem_req;
  - the cycle after ready rises, imem_req=1 at PC+1.
- Jump: at pc_out=5, present jump=1 and jump_target=8'h40 with ready=1:
  - next imem_addr=8'h40.
  - Repeat with jump=1 but ready=0: the PC is not redirected.
- Wrap, with PC forced to reach 8'hFF and no jump:
  - the fetch after accepting pc_out=8'hFF uses imem_addr=0.
  - Separately, after 65536 accepts (or preloaded counter), instr_count stays 16'hFFFF.
- Assert rst_n=0 while imem_req=1 and also while instr_valid=1:
  - all outputs go to reset values asynchronously;
  - after release with run=0, the block stays IDLE with imem_req=0.
